// File: rtl/intt_pkg.sv
// Shared constants and state encoding for the inverse-NTT sequencer.
// Optional n^-1 scaling phase is compiled in with INTT_SCALE_EN.
package intt_pkg;

  localparam int LOGN_DEF   = 3;
  localparam int N_DEF      = 1 << LOGN_DEF;
  localparam int RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF = 2;
  localparam int Q          = 65537;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_SCALE,
    S_SDRAIN,
    S_FIN
  } state_t;

endpackage

// File: rtl/intt_addr_gen.sv
// Gentleman-Sande butterfly address map: (stage s, butterfly k) to operand
// addresses and psi^-1 table index. Purely combinational, modulo 2^LOGN.
module intt_addr_gen #(
  parameter int LOGN = 3
) (
  input  logic [LOGN-1:0] s,
  input  logic [LOGN-1:0] k,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-1:0] tw_addr
);

  logic [LOGN-1:0] t;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] half;

  always_comb begin
    t       = LOGN'(1) << s;
    g       = k >> s;
    half    = LOGN'(1) << (LOGN - 1);
    addr_a  = ((g << s) << 1) | (k & (t - LOGN'(1)));
    addr_b  = addr_a + t;
    // Group g of stage s uses twiddle (N >> (s+1)) + g; index 0 is never reached.
    tw_addr = (half >> s) + g;
  end

endmodule

// File: rtl/intt_sequencer.sv
// Control FSM for the in-place inverse NTT: issues butterfly reads, twiddle
// indices and L-cycle delayed write-backs. Scaling phase under INTT_SCALE_EN.
module intt_sequencer
  import intt_pkg::*;
#(
  parameter int LOGN   = LOGN_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            scale_op,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic            wr_scale
);

  localparam int N  = 1 << LOGN;
  localparam int L  = RD_LAT + BF_LAT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int DW = 2 + 2 * LOGN;

  // Handshake: start is a level sampled only in IDLE (no queuing); done is a
  // one-cycle pulse in FIN, and start seen during FIN is dropped.
  state_t          state;
  logic [LOGN-1:0] s;
  logic [LOGN-1:0] k;
  logic [CW-1:0]   dcnt;
  logic [LOGN-1:0] gen_a;
  logic [LOGN-1:0] gen_b;
  logic [LOGN-1:0] gen_tw;
  logic [DW-1:0]   dline [L];

  intt_addr_gen #(.LOGN(LOGN)) u_addr_gen (
    .s       (s),
    .k       (k),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      s     <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_ISSUE;
          s     <= '0;
          k     <= '0;
        end
        S_ISSUE: if (k == LOGN'(N / 2 - 1)) begin
          state <= S_DRAIN;
          k     <= '0;
          dcnt  <= '0;
        end else begin
          k <= k + LOGN'(1);
        end
        // Drain lets the last writes of a stage land before the next stage reads them.
        S_DRAIN: if (dcnt == CW'(L - 1)) begin
          if (s != LOGN'(LOGN - 1)) begin
            s     <= s + LOGN'(1);
            state <= S_ISSUE;
          end else begin
`ifdef INTT_SCALE_EN
            state <= S_SCALE;
`else
            state <= S_FIN;
`endif
          end
        end else begin
          dcnt <= dcnt + CW'(1);
        end
`ifdef INTT_SCALE_EN
        S_SCALE: if (k == LOGN'(N - 1)) begin
          state <= S_SDRAIN;
          k     <= '0;
          dcnt  <= '0;
        end else begin
          k <= k + LOGN'(1);
        end
        S_SDRAIN: if (dcnt == CW'(L - 1)) begin
          state <= S_FIN;
        end else begin
          dcnt <= dcnt + CW'(1);
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en     = 1'b0;
    scale_op  = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    case (state)
      S_ISSUE: begin
        rd_en     = 1'b1;
        rd_addr_a = gen_a;
        rd_addr_b = gen_b;
        tw_addr   = gen_tw;
      end
`ifdef INTT_SCALE_EN
      S_SCALE: begin
        rd_en     = 1'b1;
        scale_op  = 1'b1;
        rd_addr_a = k;
        rd_addr_b = k;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state == S_ISSUE) || (state == S_DRAIN) ||
                (state == S_SCALE) || (state == S_SDRAIN);
  assign done = (state == S_FIN);

  // Write-back is the read command delayed by exactly L cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) dline[i] <= '0;
    end else begin
      dline[0] <= {rd_en, scale_op, rd_addr_a, rd_addr_b};
      for (int i = 1; i < L; i++) dline[i] <= dline[i-1];
    end
  end

  assign {wr_en, wr_scale, wr_addr_a, wr_addr_b} = dline[L-1];

endmodule

// File: tb/tb_intt_sequencer.sv
// Directed bench for intt_sequencer at default parameters (N = 8, L = 3);
// define INTT_SCALE_EN to check the scaling build.
module tb_intt_sequencer;

`ifdef INTT_SCALE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  localparam int DONE_CYC = SC ? 33 : 22;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, scale_op, wr_en, wr_scale;
  logic [2:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic [20:0] obs;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  intt_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .scale_op  (scale_op),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_scale  (wr_scale)
  );

  assign obs = {busy, done, rd_en, scale_op, rd_addr_a, rd_addr_b, tw_addr,
                wr_en, wr_scale, wr_addr_a, wr_addr_b};

  // Hand-computed (a, b, tw) for stages 0..2, four butterflies each.
  function automatic logic [8:0] bf_tab(input int i);
    case (i)
      0: return {3'd0, 3'd1, 3'd4};
      1: return {3'd2, 3'd3, 3'd5};
      2: return {3'd4, 3'd5, 3'd6};
      3: return {3'd6, 3'd7, 3'd7};
      4: return {3'd0, 3'd2, 3'd2};
      5: return {3'd1, 3'd3, 3'd2};
      6: return {3'd4, 3'd6, 3'd3};
      7: return {3'd5, 3'd7, 3'd3};
      8: return {3'd0, 3'd4, 3'd1};
      9: return {3'd1, 3'd5, 3'd1};
      10: return {3'd2, 3'd6, 3'd1};
      11: return {3'd3, 3'd7, 3'd1};
      default: return 9'd0;
    endcase
  endfunction

  // {rd_en, scale_op, a, b, tw} expected in cycle c (start sampled at edge 0).
  function automatic logic [10:0] rd_part(input int c);
    logic [10:0] r;
    logic [2:0]  idx;
    r = '0;
    for (int st = 0; st < 3; st++)
      if (c >= 1 + 7 * st && c <= 4 + 7 * st)
        r = {2'b10, bf_tab(st * 4 + c - 1 - 7 * st)};
    if (SC && c >= 22 && c <= 29) begin
      idx = 3'(c - 22);
      r = {2'b11, idx, idx, 3'd0};
    end
    return r;
  endfunction

  function automatic logic [20:0] exp_vec(input int c);
    logic [10:0] rp, wp;
    logic        b, d;
    rp = rd_part(c);
    wp = rd_part(c - 3);
    b  = (c >= 1) && (c < DONE_CYC);
    d  = (c == DONE_CYC);
    return {b, d, rp, wp[10:3]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs !== 21'd0) begin
      failed++;
      $display("FAIL reset_state got=%h exp=%h", obs, 21'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== 21'd0) begin
        failed++;
        $display("FAIL idle_after_reset c=%0d got=%h exp=%h", c, obs, 21'd0);
      end
    end
  endtask

  // Full schedule, with a stray start in cycle 10 that must be ignored.
  task automatic test_schedule();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 3; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec(c)) begin
        failed++;
        $display("FAIL schedule c=%0d got=%h exp=%h", c, obs, exp_vec(c));
      end
      start = (c == 10);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (obs !== exp_vec(c)) begin
        failed++;
        $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs, exp_vec(c));
      end
    end
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== 21'd0) begin
        failed++;
        $display("FAIL in_reset c=%0d got=%h exp=%h", c, obs, 21'd0);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (wr_en !== 1'b0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL post_reset_quiet c=%0d got wr_en=%b busy=%b exp 0 0", c, wr_en, busy);
      end
    end
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (obs !== exp_vec(c)) begin
        failed++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, obs, exp_vec(c));
      end
    end
  endtask

  // start in FIN is dropped; start one cycle later gives an identical run.
  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec(c)) begin
        failed++;
        $display("FAIL b2b_first c=%0d got=%h exp=%h", c, obs, exp_vec(c));
      end
      start = (c == DONE_CYC);
    end
    @(negedge clk);
    tests++;
    if (obs !== 21'd0) begin
      failed++;
      $display("FAIL b2b_fin_start_ignored got=%h exp=%h", obs, 21'd0);
    end
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (obs !== exp_vec(c)) begin
        failed++;
        $display("FAIL b2b_second c=%0d got=%h exp=%h", c, obs, exp_vec(c));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_schedule();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
